multu_hilo: RTL and testbench
=============================

# multu_hilo

Sequential 32×32 unsigned multiplier with architectural HI/LO registers for the ALU execution stage. It runs alongside the barrel shifter and shares the same `dataA`/`dataB`/`Signal` operand bus. It drives the ALU result mux on MFHI/MFLO, the same mux that consumes the shifter's `dataOut`. It uses a shift-and-add datapath with a busy/done handshake toward the stall logic.

## Interface
- `MULTU_CODE`, default 6'd25: `Signal` value that starts a multiply.
- `MFHI_CODE`, default 6'd16: `Signal` value that selects HI onto `dataOut`.
- `MFLO_CODE`, default 6'd18: `Signal` value that selects LO onto `dataOut`.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — synchronous, active-low. Sampled on the rising edge of `clk`.
- `dataA`  in  32  — multiplicand (rs).
- `dataB`  in  32  — multiplier (rt).
- `Signal`  in  6  — ALU function code.
- `dataOut`  out  32  — HI or LO read data, otherwise 0.
- `busy`  out  1  — multiply in progress; the pipeline must stall.
- `done`  out  1  — one-cycle pulse when HI/LO have just been committed.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - When `Signal==MULTU_CODE` at an edge, latch `mcand<=dataA` and `prod[63:0]<={32'b0,dataB}`, set `cnt<=0`, and go to RUN.
  - Otherwise stay in IDLE.
- **RUN** (one iteration per edge):
  - `sum[32:0] = {1'b0,prod[63:32]} + (prod[0] ? {1'b0,mcand} : 33'b0)`.
  - `prod <= {sum, prod[31:1]}`, a logical right shift that keeps the carry.
  - `cnt <= cnt+1`.
  - On the edge where `cnt==31`, write HI/LO directly from the final shifted value (HI = `sum[32:1]`, LO = `{sum[0], prod[31:1]}`) and go to DONE.
- **DONE**: the next edge always goes to IDLE. A MULTU presented while in DONE is ignored; it is only accepted in IDLE.
- HI/LO are architectural state:
  - They hold their old values for the whole of RUN.
  - They change only at the commit edge or on reset.
  - `prod` is internal and never visible.
- `Signal==MULTU_CODE` during RUN or DONE is ignored. Operands are not re-sampled.
- `dataOut` is combinational from the registered HI/LO:
  - `MFHI_CODE` gives HI.
  - `MFLO_CODE` gives LO.
  - Any other code gives `32'h0`.
  - Valid in any state. During RUN it shows the previous product.
- `busy = (state==RUN)`; `done = (state==DONE)`. Both are decoded from registered state, with no combinational path from inputs.
- Unsigned only. The product fits in 64 bits, so there is no overflow flag.

## Timing
- Reset (`reset==0` at an edge):
  - State goes to IDLE; HI, LO, `prod`, `mcand` and `cnt` go to 0.
  - `busy=0`, `done=0`, and `dataOut=0` for every `Signal`.
  - Reset has priority over everything. A reset during RUN aborts the multiply and HI/LO read 0 afterwards, not the partial product.
- Latency, with edge E0 being the edge where MULTU is accepted:
  - `busy` is high for the 32 cycles following E0, covering edges E1..E32.
  - HI/LO are updated at E32.
  - `done` is high for one cycle, between E32 and E33.
  - Earliest next MULTU acceptance is at E34, since the block is back in IDLE after E33.
- MFHI in the cycle `done` is high returns the new HI. A back-to-back MFLO follows the same rule.
- A MULTU held constant on `Signal` across DONE→IDLE starts a second multiply at E34. The stall logic must drop the MULTU code once `done` is seen.

## Test plan
1. Reset, then `dataA=3`, `dataB=5`, MULTU for one cycle:
   - `busy` is high for exactly 32 cycles.
   - `done` pulses at cycle 33.
   - MFHI then returns `0x00000000` and MFLO returns `0x0000000F`.
2. `0xFFFFFFFF × 0xFFFFFFFF`: HI=`0xFFFFFFFE`, LO=`0x00000001`. This checks carry retention in the 33-bit sum.
3. `0x80000000 × 2`: HI=`0x00000001`, LO=`0x00000000`. Then `0 × 0x12345678`: HI=LO=0.
4. After case 1, start `7 × 9`:
   - MFLO sampled during `busy` returns `0x0000000F` (old value).
   - MULTU with `dataA=100` asserted mid-RUN is ignored.
   - Final LO=`0x0000003F`.
5. Drive `reset=0` on cycle 10 of RUN:
   - Next cycle `busy=0` and `done=0`.
   - MFHI and MFLO return 0.
   - No `done` pulse follows.
   - A new `2 × 3` then gives LO=6.
6. With `Signal=6'd2` (SRL) and `Signal=6'd32` (ADD) after a non-zero product: `dataOut=0`, `busy=0`, and HI/LO are unchanged.

Source files
------------

// File: rtl/multu_hilo.sv
// Sequential 32x32 unsigned shift-and-add multiplier with architectural HI/LO
// registers, a busy/done handshake and an MFHI/MFLO read port.
module multu_hilo #(
    parameter logic [5:0] MULTU_CODE = 6'd25,
    parameter logic [5:0] MFHI_CODE  = 6'd16,
    parameter logic [5:0] MFLO_CODE  = 6'd18
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic [5:0]  Signal,
    output logic [31:0] dataOut,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:0] mcand_reg;
    logic [63:0] prod_reg;
    logic [4:0]  cnt_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic [32:0] sum_next;

    // The 33rd bit keeps the carry so the shift never loses the top of the partial product.
    assign sum_next = {1'b0, prod_reg[63:32]} + (prod_reg[0] ? {1'b0, mcand_reg} : 33'b0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            mcand_reg <= 32'b0;
            prod_reg  <= 64'b0;
            cnt_reg   <= 5'd0;
            hi_reg    <= 32'b0;
            lo_reg    <= 32'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (Signal == MULTU_CODE) begin
                        mcand_reg <= dataA;
                        prod_reg  <= {32'b0, dataB};
                        cnt_reg   <= 5'd0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    prod_reg <= {sum_next, prod_reg[31:1]};
                    cnt_reg  <= cnt_reg + 5'd1;
                    // Commit straight from the final shifted value, not from prod_reg.
                    if (cnt_reg == 5'd31) begin
                        hi_reg    <= sum_next[32:1];
                        lo_reg    <= {sum_next[0], prod_reg[31:1]};
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        dataOut = 32'h0;
        if (Signal == MFHI_CODE) begin
            dataOut = hi_reg;
        end else if (Signal == MFLO_CODE) begin
            dataOut = lo_reg;
        end
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);

endmodule

// File: tb/tb_multu_hilo.sv
// Directed-vector bench for multu_hilo: handshake timing, products, reads and reset abort.
module tb_multu_hilo;

    localparam logic [5:0] MULTU = 6'd25;
    localparam logic [5:0] MFHI  = 6'd16;
    localparam logic [5:0] MFLO  = 6'd18;

    logic        clk;
    logic        reset;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  Signal;
    logic [31:0] dataOut;
    logic        busy;
    logic        done;

    int check_count;
    int error_count;

    multu_hilo dut (
        .clk     (clk),
        .reset   (reset),
        .dataA   (dataA),
        .dataB   (dataB),
        .Signal  (Signal),
        .dataOut (dataOut),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        Signal = MFHI;
        #1 check({tag, " HI"}, dataOut, exp_hi);
        Signal = MFLO;
        #1 check({tag, " LO"}, dataOut, exp_lo);
        Signal = 6'd0;
    endtask

    // Full multiply with handshake timing checks; ends at the negedge after E33.
    task automatic do_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int busy_cycles;
        @(negedge clk);
        dataA  = a;
        dataB  = b;
        Signal = MULTU;
        @(negedge clk);
        Signal = 6'd0;
        busy_cycles = 0;
        for (int i = 0; i < 32; i++) begin
            if (busy && !done) busy_cycles++;
            @(negedge clk);
        end
        check({tag, " busy cycles"}, busy_cycles, 32);
        check({tag, " done at 33"}, {busy, done}, 2'b01);
        read_hilo(tag, exp_hi, exp_lo);
        @(negedge clk);
        check({tag, " after done"}, {busy, done}, 2'b00);
    endtask

    initial begin
        int seen_done;
        int waited;
        check_count = 0;
        error_count = 0;
        reset  = 1'b0;
        dataA  = 32'd0;
        dataB  = 32'd0;
        Signal = 6'd0;
        repeat (2) @(negedge clk);
        check("reset busy/done", {busy, done}, 2'b00);
        read_hilo("reset", 32'h0, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        do_mult("3x5", 32'd3, 32'd5, 32'h0, 32'h0000000F);

        // Old product visible during RUN, and a mid-run MULTU is ignored.
        @(negedge clk);
        dataA  = 32'd7;
        dataB  = 32'd9;
        Signal = MULTU;
        @(negedge clk);
        Signal = 6'd0;
        repeat (4) @(negedge clk);
        Signal = MFLO;
        #1 check("mid-run MFLO old", dataOut, 32'h0000000F);
        check("mid-run busy", busy, 1'b1);
        @(negedge clk);
        dataA  = 32'd100;
        Signal = MULTU;
        @(negedge clk);
        Signal = 6'd0;
        waited = 0;
        while (!done && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("7x9 done seen", done, 1'b1);
        read_hilo("7x9", 32'h0, 32'h0000003F);
        @(negedge clk);
        @(negedge clk);
        check("7x9 no restart", busy, 1'b0);

        do_mult("ffxff", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        do_mult("8e7x2", 32'h80000000, 32'd2, 32'h00000001, 32'h00000000);
        do_mult("0xk", 32'd0, 32'h12345678, 32'h0, 32'h0);
        do_mult("big", 32'h12345678, 32'h10, 32'h00000001, 32'h23456780);

        // Reset on cycle 10 of RUN aborts the multiply.
        @(negedge clk);
        dataA  = 32'h12345678;
        dataB  = 32'h9ABCDEF0;
        Signal = MULTU;
        @(negedge clk);
        Signal = 6'd0;
        repeat (9) @(negedge clk);
        check("abort busy before", busy, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort busy/done", {busy, done}, 2'b00);
        read_hilo("abort", 32'h0, 32'h0);
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        check("abort no done", seen_done, 0);

        do_mult("2x3", 32'd2, 32'd3, 32'h0, 32'h6);

        // Non-HI/LO codes read zero and disturb nothing.
        Signal = 6'd2;
        #1 check("SRL dataOut", dataOut, 32'h0);
        check("SRL busy", busy, 1'b0);
        @(negedge clk);
        Signal = 6'd32;
        #1 check("ADD dataOut", dataOut, 32'h0);
        @(negedge clk);
        check("ADD busy", busy, 1'b0);
        read_hilo("unchanged", 32'h0, 32'h6);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
